// File: rtl/quad_decoder_ud.sv
// Quadrature decoder: A/B encoder phases in, registered up/down/err strobes out.
// Ports: clk, reset (sync, active-high), a/b async phases, en gates up/down,
//   up/down one-cycle step strobes, err illegal two-bit jump, ready in RUN.
module quad_decoder_ud #(
   parameter int unsigned FILT = 4,
   parameter int unsigned RES  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   input  logic en,
   output logic up,
   output logic down,
   output logic err,
   output logic ready
);

   localparam int unsigned CW = $clog2(FILT + 1);
   localparam logic [CW-1:0] C_MAX  = CW'(FILT - 1);
   localparam logic [CW-1:0] C_FULL = CW'(FILT);

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   // Synchroniser flops carry no reset so phases held through reset are
   // already settled when it is released.
   logic a_m_q, a_s_q;
   logic b_m_q, b_s_q;

   always_ff @(posedge clk) begin
      a_m_q <= a;
      a_s_q <= a_m_q;
      b_m_q <= b;
      b_s_q <= b_m_q;
   end

   // Bit 1 is phase A, bit 0 is phase B throughout.
   logic [1:0] s;
   assign s = {a_s_q, b_s_q};

   logic [0:0]    state_q, state_d;
   logic [1:0]    f_q, f_d;
   logic [1:0]    prev_q, prev_d;
   logic [CW-1:0] c_q [2];
   logic [CW-1:0] c_d [2];
   logic          up_q, up_d;
   logic          down_q, down_d;
   logic          err_q, err_d;
   logic          gate;

   function automatic logic [1:0] fwd_next(input logic [1:0] p);
      unique case (p)
         2'b00:   fwd_next = 2'b10;
         2'b10:   fwd_next = 2'b11;
         2'b11:   fwd_next = 2'b01;
         default: fwd_next = 2'b00;
      endcase
   endfunction

   // Resolution gate depends only on the state being entered.
   always_comb begin
      gate = 1'b0;
      if (RES == 4) begin
         gate = 1'b1;
      end else if (RES == 2) begin
         gate = (f_q == 2'b00) || (f_q == 2'b11);
      end else begin
         gate = (f_q == 2'b00);
      end
   end

   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      prev_d  = prev_q;
      c_d     = c_q;
      up_d    = 1'b0;
      down_d  = 1'b0;
      err_d   = 1'b0;
      if (state_q == S_INIT) begin
         // f follows the input; c counts consecutive unchanged cycles.
         for (int i = 0; i < 2; i++) begin
            if (s[i] != f_q[i]) begin
               f_d[i] = s[i];
               c_d[i] = '0;
            end else if (c_q[i] != C_FULL) begin
               c_d[i] = c_q[i] + CW'(1);
            end
         end
         // Keep the proven-stable value even if the input moves now.
         if (c_q[0] == C_FULL && c_q[1] == C_FULL) begin
            state_d = S_RUN;
            f_d     = f_q;
            prev_d  = f_q;
            c_d[0]  = '0;
            c_d[1]  = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (s[i] == f_q[i]) begin
               c_d[i] = '0;
            end else if (c_q[i] == C_MAX) begin
               f_d[i] = s[i];
               c_d[i] = '0;
            end else begin
               c_d[i] = c_q[i] + CW'(1);
            end
         end
         if (f_q != prev_q) begin
            prev_d = f_q;
            if (&(f_q ^ prev_q)) begin
               err_d = 1'b1;
            end else if (fwd_next(prev_q) == f_q) begin
               up_d = gate & en;
            end else begin
               down_d = gate & en;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_INIT;
         f_q     <= 2'b00;
         prev_q  <= 2'b00;
         c_q[0]  <= '0;
         c_q[1]  <= '0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         prev_q  <= prev_d;
         c_q     <= c_d;
         up_q    <= up_d;
         down_q  <= down_d;
         err_q   <= err_d;
      end
   end

   assign up    = up_q;
   assign down  = down_q;
   assign err   = err_q;
   assign ready = (state_q == S_RUN);

endmodule

// File: tb/tb_quad_decoder_ud.sv
// Bench for quad_decoder_ud: three resolutions driven in parallel,
// directed plan steps then random phases against a reference model.
module tb_quad_decoder_ud;

   localparam int FILT = 4;
   localparam int NH   = 8192;

   logic clk = 1'b0;
   logic reset, a, b, en;
   logic [2:0] up_w, dn_w, er_w, rd_w;

   int checks = 0;
   int errors = 0;
   int n = 0;

   bit ah [NH];
   bit bh [NH];
   int rv [3] = '{4, 2, 1};

   bit       m_run;
   bit [1:0] mf, mprev;
   int       lacc [2];
   bit       qa [$];
   bit       qb [$];
   bit [2:0] eu, ed;
   bit       ee;

   int cu [3];
   int cd [3];
   int ce, first_up, tk, rdy_lat;

   always #5 clk = ~clk;

   quad_decoder_ud #(.FILT(FILT), .RES(4)) u4 (
      .clk(clk), .reset(reset), .a(a), .b(b), .en(en),
      .up(up_w[0]), .down(dn_w[0]), .err(er_w[0]), .ready(rd_w[0])
   );
   quad_decoder_ud #(.FILT(FILT), .RES(2)) u2 (
      .clk(clk), .reset(reset), .a(a), .b(b), .en(en),
      .up(up_w[1]), .down(dn_w[1]), .err(er_w[1]), .ready(rd_w[1])
   );
   quad_decoder_ud #(.FILT(FILT), .RES(1)) u1 (
      .clk(clk), .reset(reset), .a(a), .b(b), .en(en),
      .up(up_w[2]), .down(dn_w[2]), .err(er_w[2]), .ready(rd_w[2])
   );

   // Position of a phase pair along the forward cycle 00,10,11,01.
   function automatic int pos(bit [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Synchronised phase seen by the decoder at edge k (two edges late).
   function automatic bit sy(int ch, int k);
      if (k < 2) return 1'b0;
      return (ch == 1) ? ah[k-2] : bh[k-2];
   endfunction

   function automatic bit stable(bit q [$]);
      if (q.size() < FILT + 1) return 1'b0;
      for (int i = q.size() - FILT - 1; i < q.size(); i++)
         if (q[i] != q[q.size()-1]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step();
      bit [1:0] cur;
      int d, p;
      bit acc;
      eu = '0;
      ed = '0;
      ee = 1'b0;
      if (reset) begin
         m_run = 1'b0;
         mf    = 2'b00;
         mprev = 2'b00;
         qa.delete();
         qb.delete();
         qa.push_back(1'b0);
         qb.push_back(1'b0);
      end else if (!m_run) begin
         if (stable(qa) && stable(qb)) begin
            m_run   = 1'b1;
            mf      = {qa[$], qb[$]};
            mprev   = mf;
            lacc[0] = n;
            lacc[1] = n;
         end else begin
            qa.push_back(sy(1, n));
            qb.push_back(sy(0, n));
         end
      end else begin
         cur = mf;
         if (cur != mprev) begin
            d = (pos(cur) - pos(mprev) + 4) % 4;
            p = pos(cur);
            if (d == 2) begin
               ee = 1'b1;
            end else begin
               for (int r = 0; r < 3; r++) begin
                  if (en && (rv[r] == 4 || (rv[r] == 2 && p % 2 == 0)
                             || p == 0)) begin
                     if (d == 1) eu[r] = 1'b1;
                     else        ed[r] = 1'b1;
                  end
               end
            end
            mprev = cur;
         end
         // A new level is accepted after FILT differing samples in a row.
         for (int ch = 0; ch < 2; ch++) begin
            if (n - lacc[ch] >= FILT) begin
               acc = 1'b1;
               for (int k = 0; k < FILT; k++)
                  if (sy(ch, n - k) == mf[ch]) acc = 1'b0;
               if (acc) begin
                  mf[ch]   = ~mf[ch];
                  lacc[ch] = n;
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0d expected %0d",
                tag, n, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      n++;
      if (n < NH) begin
         ah[n] = a;
         bh[n] = b;
      end
      model_step();
      #1;
      for (int r = 0; r < 3; r++) begin
         chk($sformatf("up_r%0d", rv[r]), 32'(up_w[r]), 32'(eu[r]));
         chk($sformatf("down_r%0d", rv[r]), 32'(dn_w[r]), 32'(ed[r]));
         chk($sformatf("err_r%0d", rv[r]), 32'(er_w[r]), 32'(ee));
         chk($sformatf("ready_r%0d", rv[r]), 32'(rd_w[r]), 32'(m_run));
         cu[r] += int'(up_w[r]);
         cd[r] += int'(dn_w[r]);
      end
      ce += int'(er_w[0]);
      tk++;
      if (up_w[0] && first_up < 0) first_up = tk;
   endtask

   task automatic clr();
      for (int r = 0; r < 3; r++) begin
         cu[r] = 0;
         cd[r] = 0;
      end
      ce       = 0;
      tk       = 0;
      first_up = -1;
   endtask

   task automatic hold(input bit na, input bit nb, input int cyc);
      a = na;
      b = nb;
      repeat (cyc) tick();
   endtask

   initial begin
      a     = 1'b1;
      b     = 1'b1;
      en    = 1'b1;
      reset = 1'b1;
      clr();
      repeat (4) tick();

      // Reset then INIT with 11 held.
      reset   = 1'b0;
      clr();
      rdy_lat = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (rd_w[0] && rdy_lat < 0) rdy_lat = i;
      end
      chk("t1_ready_lat", rdy_lat, 6);
      chk("t1_strobes", cu[0] + cd[0] + ce, 0);

      // Forward full cycle from 00.
      reset = 1'b1;
      a = 1'b0;
      b = 1'b0;
      repeat (4) tick();
      reset = 1'b0;
      repeat (10) tick();
      clr();
      hold(1, 0, 10);
      chk("t2_up_lat", first_up, FILT + 3);
      hold(1, 1, 10);
      hold(0, 1, 10);
      hold(0, 0, 10);
      chk("t2_up_res4", cu[0], 4);
      chk("t2_up_res2", cu[1], 2);
      chk("t2_up_res1", cu[2], 1);
      chk("t2_down_res4", cd[0], 0);

      // Reverse full cycle.
      clr();
      hold(0, 1, 10);
      hold(1, 1, 10);
      hold(1, 0, 10);
      hold(0, 0, 10);
      chk("t3_down_res4", cd[0], 4);
      chk("t3_down_res2", cd[1], 2);
      chk("t3_down_res1", cd[2], 1);
      chk("t3_up_res4", cu[0], 0);

      // Glitch rejection.
      clr();
      hold(1, 0, FILT - 1);
      hold(0, 0, 12);
      chk("t4_short_pulse", cu[0] + cd[0] + ce, 0);
      clr();
      hold(1, 0, FILT);
      hold(0, 0, 12);
      chk("t4_pulse_up", cu[0], 1);
      chk("t4_pulse_down", cd[0], 1);

      // Illegal jump then a legal step.
      clr();
      hold(1, 1, 10);
      chk("t5_err", ce, 1);
      chk("t5_no_step", cu[0] + cd[0], 0);
      clr();
      hold(0, 1, 10);
      chk("t5_up_after", cu[0], 1);
      hold(0, 0, 10);

      // Enable gating, then reset just after an A edge.
      clr();
      en = 1'b0;
      hold(1, 0, 10);
      hold(1, 1, 10);
      hold(0, 1, 10);
      hold(0, 0, 10);
      chk("t6_en_off", cu[0] + cd[0], 0);
      en = 1'b1;
      clr();
      hold(1, 0, 10);
      chk("t6_en_on", cu[0], 1);
      clr();
      a = 1'b0;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("t6_rst_ready", 32'(rd_w[0]), 0);
      reset = 1'b0;
      repeat (12) tick();
      chk("t6_rst_strobes", cu[0] + cd[0] + ce, 0);

      // Random phase activity with occasional enable drops and resets.
      for (int seg = 0; seg < 250; seg++) begin
         a     = 1'($urandom_range(0, 1));
         b     = 1'($urandom_range(0, 1));
         en    = ($urandom_range(0, 7) != 0);
         reset = ($urandom_range(0, 40) == 0);
         repeat ($urandom_range(1, 12)) tick();
      end
      reset = 1'b0;
      repeat (20) tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
